// File: rtl/segway_stim_pkg.sv
// Shared types for the Segway stimulus sequencer: FSM states, script step record, command codes.
// Step fields are held at a fixed 32-bit container width, so LEAN_W and GAP_W must not exceed 32.
package segway_stim_pkg;

  localparam int STIM_VAL_W = 32;

  localparam logic [7:0] CMD_GO   = 8'h47;
  localparam logic [7:0] CMD_STOP = 8'h53;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_TX,
    ST_RAMP,
    ST_HOLD,
    ST_FIN
  } stim_state_e;

  typedef struct packed {
    logic                  has_cmd;
    logic [7:0]            cmd;
    logic [STIM_VAL_W-1:0] lean;
    logic [STIM_VAL_W-1:0] gap;
  } stim_step_t;

endpackage

// File: rtl/segway_stim_seq_lean_ramp.sv
// Rate-limited lean generator: moves lean toward target by at most RAMP_STEP every RAMP_DIV clocks.
// at_target_o looks at the next lean value so the sequencer leaves RAMP on the edge the target lands.
module lean_ramp #(
  parameter int          LEAN_W    = 16,
  parameter int unsigned RAMP_STEP = 16'h0010,
  parameter int          RAMP_DIV  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic [LEAN_W-1:0] target_i,
  output logic [LEAN_W-1:0] lean_o,
  output logic              at_target_o
);

  localparam int              CW   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [LEAN_W:0] STEP = (LEAN_W+1)'(RAMP_STEP);

  logic [CW-1:0]       div_q;
  logic [LEAN_W-1:0]   lean_q, lean_d;
  logic                div_wrap, tick;
  logic signed [LEAN_W:0] diff;
  logic [LEAN_W:0]     mag;

  assign div_wrap = (div_q == CW'(RAMP_DIV - 1));
  assign tick     = en_i && ((RAMP_STEP == 0) || div_wrap);

  // One extra bit keeps the signed difference exact, so the step never wraps or overshoots.
  always_comb begin
    diff   = $signed({target_i[LEAN_W-1], target_i}) - $signed({lean_q[LEAN_W-1], lean_q});
    mag    = diff[LEAN_W] ? (~diff + 1'b1) : diff;
    lean_d = lean_q;
    if (tick) begin
      if ((RAMP_STEP == 0) || (mag <= STEP)) lean_d = target_i;
      else if (diff[LEAN_W])                 lean_d = lean_q - LEAN_W'(RAMP_STEP);
      else                                   lean_d = lean_q + LEAN_W'(RAMP_STEP);
    end
  end

  assign at_target_o = (lean_d == target_i);
  assign lean_o      = lean_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      lean_q <= '0;
    end else begin
      div_q  <= (en_i && !div_wrap) ? div_q + 1'b1 : '0;
      lean_q <= lean_d;
    end
  end

endmodule

// File: rtl/segway_stim_seq.sv
// Script-driven rider stimulus: per step, optionally send a UART command byte, ramp rider_lean
// to the step target, then hold for the programmed gap before moving on (optionally looping).
module segway_stim_seq import segway_stim_pkg::*; #(
  parameter int          NUM_STEPS = 16,
  parameter int          LEAN_W    = 16,
  parameter int          GAP_W     = 24,
  parameter int unsigned RAMP_STEP = 16'h0010,
  parameter int          RAMP_DIV  = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [$clog2(NUM_STEPS)-1:0] wr_addr,
  input  logic                         wr_has_cmd,
  input  logic [7:0]                   wr_cmd,
  input  logic [LEAN_W-1:0]            wr_lean,
  input  logic [GAP_W-1:0]             wr_gap,
  input  logic [$clog2(NUM_STEPS)-1:0] last_idx,
  input  logic                         loop,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         tx_done,
  output logic                         trmt,
  output logic [7:0]                   tx_data,
  output logic [LEAN_W-1:0]            rider_lean,
  output logic [$clog2(NUM_STEPS)-1:0] step_idx,
  output logic                         busy,
  output logic                         done
);

  localparam int AW = $clog2(NUM_STEPS);

  stim_step_t        script_q [NUM_STEPS];
  stim_state_e       state_q;
  logic [AW-1:0]     step_q, last_q, nxt_idx;
  logic              loop_q;
  logic [GAP_W-1:0]  gap_q;
  logic              trmt_q, busy_q, done_q;
  logic [7:0]        tx_data_q;
  logic              ramp_en, at_target;

  // Step that the next SEND will execute: 0 on start or wrap, otherwise the successor.
  assign nxt_idx = (state_q == ST_IDLE || step_q >= last_q) ? '0 : step_q + 1'b1;
  assign ramp_en = (state_q == ST_RAMP) && !abort;

  lean_ramp #(
    .LEAN_W   (LEAN_W),
    .RAMP_STEP(RAMP_STEP),
    .RAMP_DIV (RAMP_DIV)
  ) u_ramp (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (ramp_en),
    .target_i   (script_q[step_q].lean[LEAN_W-1:0]),
    .lean_o     (rider_lean),
    .at_target_o(at_target)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      step_q    <= '0;
      last_q    <= '0;
      loop_q    <= 1'b0;
      gap_q     <= '0;
      trmt_q    <= 1'b0;
      tx_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < NUM_STEPS; i++) script_q[i] <= '0;
    end else begin
      trmt_q <= 1'b0;
      done_q <= 1'b0;
      if (state_q == ST_IDLE && wr_en && int'(wr_addr) < NUM_STEPS)
        script_q[wr_addr] <= '{has_cmd: wr_has_cmd, cmd: wr_cmd,
                               lean: STIM_VAL_W'(wr_lean), gap: STIM_VAL_W'(wr_gap)};
      if (abort) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: if (start) begin
            step_q  <= '0;
            last_q  <= (int'(last_idx) > NUM_STEPS - 1) ? AW'(NUM_STEPS - 1) : last_idx;
            loop_q  <= loop;
            busy_q  <= 1'b1;
            state_q <= ST_SEND;
            // trmt is launched on entry so it is high during the SEND cycle itself.
            trmt_q  <= script_q[nxt_idx].has_cmd;
            if (script_q[nxt_idx].has_cmd) tx_data_q <= script_q[nxt_idx].cmd;
          end
          ST_SEND:    state_q <= script_q[step_q].has_cmd ? ST_WAIT_TX : ST_RAMP;
          ST_WAIT_TX: if (tx_done) state_q <= ST_RAMP;
          ST_RAMP: if (at_target) begin
            gap_q   <= script_q[step_q].gap[GAP_W-1:0];
            state_q <= ST_HOLD;
          end
          ST_HOLD: begin
            if (gap_q != '0) begin
              gap_q <= gap_q - 1'b1;
            end else if (step_q < last_q || loop_q) begin
              step_q  <= nxt_idx;
              state_q <= ST_SEND;
              trmt_q  <= script_q[nxt_idx].has_cmd;
              if (script_q[nxt_idx].has_cmd) tx_data_q <= script_q[nxt_idx].cmd;
            end else begin
              state_q <= ST_FIN;
              done_q  <= 1'b1;
            end
          end
          ST_FIN: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign trmt     = trmt_q;
  assign tx_data  = tx_data_q;
  assign step_idx = step_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_segway_stim_seq.sv
// Randomized scoreboard bench for segway_stim_seq: a script-level model predicts every trmt/done
// event (byte, lean, step, cycle) and a monitor checks them as the DUT produces them.
module tb_segway_stim_seq;

  localparam int RSTEP = 16;
  localparam int RDIV  = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        wr_en = 0, wr_has_cmd = 0, loop = 0, start = 0, abort = 0, tx_done = 0;
  logic [1:0]  wr_addr = '0, last_idx = '0, step_idx;
  logic [7:0]  wr_cmd = '0, tx_data;
  logic [15:0] wr_lean = '0, rider_lean;
  logic [23:0] wr_gap = '0;
  logic        trmt, busy, done;

  segway_stim_seq #(.NUM_STEPS(3), .LEAN_W(16), .GAP_W(24), .RAMP_STEP(RSTEP), .RAMP_DIV(RDIV)) u_dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_has_cmd(wr_has_cmd),
    .wr_cmd(wr_cmd), .wr_lean(wr_lean), .wr_gap(wr_gap), .last_idx(last_idx), .loop(loop),
    .start(start), .abort(abort), .tx_done(tx_done), .trmt(trmt), .tx_data(tx_data),
    .rider_lean(rider_lean), .step_idx(step_idx), .busy(busy), .done(done));

  // Second instance with RAMP_STEP=0 for the jump-to-target case.
  logic        j_wr_en = 0, j_has = 0, j_loop = 0, j_start = 0, j_abort = 0, j_tx_done = 0;
  logic [0:0]  j_addr = '0, j_last = '0, j_step;
  logic [7:0]  j_cmd = '0, j_tx_data;
  logic [15:0] j_wlean = '0, j_lean;
  logic [23:0] j_gap = '0;
  logic        j_trmt, j_busy, j_done;

  segway_stim_seq #(.NUM_STEPS(2), .LEAN_W(16), .GAP_W(24), .RAMP_STEP(0), .RAMP_DIV(RDIV)) u_jump (
    .clk(clk), .rst_n(rst_n), .wr_en(j_wr_en), .wr_addr(j_addr), .wr_has_cmd(j_has),
    .wr_cmd(j_cmd), .wr_lean(j_wlean), .wr_gap(j_gap), .last_idx(j_last), .loop(j_loop),
    .start(j_start), .abort(j_abort), .tx_done(j_tx_done), .trmt(j_trmt), .tx_data(j_tx_data),
    .rider_lean(j_lean), .step_idx(j_step), .busy(j_busy), .done(j_done));

  typedef struct {
    bit          is_done;
    logic [7:0]  data;
    logic [15:0] lean;
    logic [1:0]  step;
    int          cyc;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0, n_fail = 0;
  int  cyc = 0;
  int  tx_lat = 2;
  int  lean_ref = 0;
  bit  sc_has[3];
  int  sc_cmd[3], sc_lean[3], sc_gap[3];

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Script-level reference: each step costs SEND + tx wait + ramp + (gap+1) cycles.
  task automatic predict(input int lst_in, input bit lp, input int iters, input bit with_done, input int t_send);
    int t = t_send;
    int lst = (lst_in > 2) ? 2 : lst_in;
    for (int it = 0; it < iters; it++)
      for (int i = 0; i <= lst; i++) begin
        int d, a, r;
        if (sc_has[i]) exp_q.push_back('{0, 8'(sc_cmd[i]), 16'(lean_ref), 2'(i), t});
        d = sc_lean[i] - lean_ref;
        a = (d < 0) ? -d : d;
        r = (d == 0) ? 1 : ((a + RSTEP - 1) / RSTEP) * RDIV;
        t += 1 + (sc_has[i] ? tx_lat : 0) + r + sc_gap[i] + 1;
        lean_ref = sc_lean[i];
      end
    if (with_done && !lp) exp_q.push_back('{1, 8'h00, 16'(lean_ref), 2'(lst), t});
  endtask

  // Monitor: every trmt or done pulse must match the head of the expectation queue.
  bit done_prev = 0;
  always @(negedge clk) begin
    ev_t e;
    if (!rst_n) done_prev = 0;
    else begin
      if (done_prev) chk("busy_after_done", busy, 0);
      done_prev = done;
      if (trmt === 1'b1 || done === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_event: trmt=%b done=%b cycle %0d, nothing expected", trmt, done, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("ev_is_done", done, e.is_done);
          if (!e.is_done) chk("tx_data", tx_data, e.data);
          chk("ev_lean", rider_lean, e.lean);
          chk("ev_step", step_idx, e.step);
          chk("ev_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // Ramp shape: each lean change is at most RAMP_STEP and at least RAMP_DIV cycles apart.
  bit          have_prev = 0;
  logic [15:0] lean_prev;
  int          last_chg = -100;
  always @(negedge clk) begin
    int d;
    if (!rst_n) begin have_prev = 0; last_chg = -100; end
    else begin
      if (have_prev && rider_lean !== lean_prev) begin
        d = int'($signed(rider_lean)) - int'($signed(lean_prev));
        chk("ramp_delta_ok", (d <= RSTEP && d >= -RSTEP), 1);
        chk("ramp_spacing_ok", (cyc - last_chg >= RDIV), 1);
        last_chg = cyc;
      end
      lean_prev = rider_lean;
      have_prev = 1;
    end
  end

  // UART_tx stand-in: tx_done pulse tx_lat cycles after each trmt.
  initial forever begin
    @(negedge clk);
    if (rst_n && trmt === 1'b1) begin
      repeat (tx_lat) @(negedge clk);
      tx_done = 1;
      @(negedge clk);
      tx_done = 0;
    end
  end

  task automatic write_step(input int a, input bit h, input logic [7:0] c, input logic [15:0] l,
                            input int g, input bit upd);
    @(negedge clk);
    wr_en = 1; wr_addr = 2'(a); wr_has_cmd = h; wr_cmd = c; wr_lean = l; wr_gap = 24'(g);
    if (upd) begin sc_has[a] = h; sc_cmd[a] = int'(c); sc_lean[a] = int'($signed(l)); sc_gap[a] = g; end
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic start_run(input int lst, input bit lp, input int iters, input bit with_done);
    @(negedge clk);
    last_idx = 2'(lst); loop = lp; start = 1;
    predict(lst, lp, iters, with_done, cyc + 1);
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < budget) begin @(negedge clk); k++; end
    chk(nm, (k < budget), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // Reset state, with start pulsed while reset is held.
    repeat (2) @(negedge clk);
    start = 1;
    @(negedge clk);
    chk("rst_trmt", trmt, 0);   chk("rst_tx_data", tx_data, 0); chk("rst_lean", rider_lean, 0);
    chk("rst_step", step_idx, 0); chk("rst_busy", busy, 0);    chk("rst_done", done, 0);
    start = 0;
    @(negedge clk); rst_n = 1;
    repeat (2) @(negedge clk);
    chk("start_in_reset_ignored", busy, 0);

    // Power-up command.
    tx_lat = 3;
    write_step(0, 1, 8'h47, 16'h0000, 10, 1);
    start_run(0, 0, 1, 1);
    wait_idle(200, "powerup_finish");

    // Ramp rate to 0x0FFF, gap 0.
    write_step(0, 0, 8'h00, 16'h0FFF, 0, 1);
    start_run(0, 0, 1, 1);
    wait_idle(2000, "ramp_finish");

    // Random scripts (last_idx 3 exercises the clamp to 2).
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 3; i++)
        write_step(i, 1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom_range(0, 4096)) - 16'd2048,
                   $urandom_range(0, 12), 1);
      tx_lat = $urandom_range(1, 4);
      start_run($urandom_range(0, 3), 0, 1, 1);
      wait_idle(8000, "rand_finish");
    end

    // Loop with a negative target; writes and start while busy must be ignored.
    tx_lat = 2;
    write_step(0, 0, 8'h00, 16'h0FFF, 3, 1);
    write_step(1, 1, 8'h53, 16'hF001, 3, 1);
    start_run(1, 1, 2, 0);
    repeat (40) @(negedge clk);
    write_step(1, 1, 8'h99, 16'h0000, 0, 0);
    start = 1; @(negedge clk); start = 0;
    k = 0;
    while (exp_q.size() != 0 && k < 15000) begin @(negedge clk); k++; end
    chk("loop_events_seen", (k < 15000), 1);
    repeat (50) @(negedge clk);
    chk("loop_still_busy", busy, 1);
    abort = 1; @(negedge clk); abort = 0;
    chk("loop_abort_busy", busy, 0);
    chk("loop_abort_trmt", trmt, 0);
    chk("loop_abort_done", done, 0);

    // Reset asserted mid-RAMP clears outputs immediately and the script.
    last_idx = 2'd0; loop = 0; start = 1; @(negedge clk); start = 0;
    repeat (30) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    #2 rst_n = 0;
    #1;
    chk("midrst_lean", rider_lean, 0); chk("midrst_busy", busy, 0);   chk("midrst_step", step_idx, 0);
    chk("midrst_trmt", trmt, 0);       chk("midrst_tx_data", tx_data, 0); chk("midrst_done", done, 0);
    @(negedge clk); start = 1; @(negedge clk); start = 0;
    @(negedge clk); rst_n = 1;
    lean_ref = 0;
    for (int i = 0; i < 3; i++) begin sc_has[i] = 0; sc_cmd[i] = 0; sc_lean[i] = 0; sc_gap[i] = 0; end
    chk("queue_empty_after_reset", exp_q.size(), 0);
    start_run(0, 0, 1, 1);
    wait_idle(100, "cleared_script_finish");

    // Abort during WAIT_TX; the late tx_done must not revive the sequencer.
    tx_lat = 6;
    write_step(0, 1, 8'h47, 16'h0100, 0, 1);
    k = lean_ref;
    start_run(0, 0, 1, 0);
    lean_ref = k;
    @(negedge clk); abort = 1;
    @(negedge clk); abort = 0;
    chk("abort_busy", busy, 0); chk("abort_trmt", trmt, 0); chk("abort_lean", rider_lean, 16'(lean_ref));
    repeat (12) @(negedge clk);
    chk("abort_late_busy", busy, 0); chk("abort_late_lean", rider_lean, 16'(lean_ref));
    chk("abort_late_step", step_idx, 0); chk("abort_queue_empty", exp_q.size(), 0);

    // RAMP_STEP=0 instance: lean jumps in one cycle, gap 0 gives a single HOLD cycle.
    @(negedge clk); j_wr_en = 1; j_addr = 1'b0; j_has = 0; j_wlean = 16'h1234; j_gap = 24'd0;
    @(negedge clk); j_wr_en = 0; j_last = 1'b0; j_start = 1;
    @(negedge clk); j_start = 0;
    chk("jump_send_busy", j_busy, 1); chk("jump_send_lean", j_lean, 0);
    @(negedge clk); chk("jump_ramp_lean", j_lean, 0);
    @(negedge clk); chk("jump_hold_lean", j_lean, 16'h1234); chk("jump_hold_done", j_done, 0);
    @(negedge clk); chk("jump_fin_done", j_done, 1); chk("jump_trmt", j_trmt, 0);
    chk("jump_step", j_step, 0); chk("jump_tx_data", j_tx_data, 0);
    @(negedge clk); chk("jump_idle_busy", j_busy, 0);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
